// File: rtl/dmem_responder_pkg.sv
// Shared pipeline-flow types for the MEM stage and the data-memory responder.
package dmem_responder_pkg;

  // Access size carried by a load/store request.
  typedef enum logic [1:0] {
    MEM_SIZE_B   = 2'd0,
    MEM_SIZE_H   = 2'd1,
    MEM_SIZE_W   = 2'd2,
    MEM_SIZE_RSV = 2'd3
  } mem_size_t;

  // True when the low address bits do not match the natural alignment of the size.
  function automatic logic mem_misaligned(input mem_size_t size, input logic [1:0] addr_lo);
    case (size)
      MEM_SIZE_H: mem_misaligned = addr_lo[0];
      MEM_SIZE_W: mem_misaligned = (addr_lo != 2'b00);
      default:    mem_misaligned = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// Request/response bundle between the MEM stage (master) and the responder (slave).
interface dmem_responder_if
  import dmem_responder_pkg::*;
#(
  parameter int ADDR_W = 32
) ();

  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  mem_size_t         req_size;
  logic              req_unsigned;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;

  logic              rsp_valid;
  logic              rsp_ready;
  logic [31:0]       rsp_rdata;
  logic              rsp_err;

  modport master (
    output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );

endinterface

// File: rtl/dmem_responder_lane_align.sv
// Byte-lane steering between a right-aligned request and a 32-bit array word.
module dmem_lane_align
  import dmem_responder_pkg::*;
(
  input  mem_size_t   size,
  input  logic [1:0]  addr_lo,
  input  logic        is_unsigned,
  input  logic [31:0] st_data,
  output logic [3:0]  st_be,
  output logic [31:0] st_word,
  input  logic [31:0] ld_word,
  output logic [31:0] ld_data
);

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  // Store path: enable the addressed lanes and replicate data so every lane sees it.
  always_comb begin
    st_be   = 4'b0000;
    st_word = st_data;
    case (size)
      MEM_SIZE_B: begin
        st_be   = 4'b0001 << addr_lo;
        st_word = {4{st_data[7:0]}};
      end
      MEM_SIZE_H: begin
        st_be   = addr_lo[1] ? 4'b1100 : 4'b0011;
        st_word = {2{st_data[15:0]}};
      end
      MEM_SIZE_W: st_be = 4'b1111;
      default:    st_be = 4'b0000;
    endcase
  end

  // Load path: pick the addressed lane(s) and extend to 32 bits.
  always_comb begin
    ld_byte = ld_word[{addr_lo, 3'b000} +: 8];
    ld_half = addr_lo[1] ? ld_word[31:16] : ld_word[15:0];
    ld_data = '0;
    case (size)
      MEM_SIZE_B: ld_data = {{24{~is_unsigned & ld_byte[7]}}, ld_byte};
      MEM_SIZE_H: ld_data = {{16{~is_unsigned & ld_half[15]}}, ld_half};
      MEM_SIZE_W: ld_data = ld_word;
      default:    ld_data = '0;
    endcase
  end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: one outstanding request, fixed access latency,
// byte/half/word stores and extended loads on a word-organised array.
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 2
) (
  input  logic            clk,
  input  logic            reset,
  dmem_responder_if.slave bus
);

  localparam int                IDX_W    = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam int                CNT_W    = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CNT_W-1:0]  CNT_INIT = CNT_W'(LATENCY - 1);
  localparam logic [ADDR_W-1:0] DEPTH_L  = ADDR_W'(DEPTH_WORDS);

  if (LATENCY < 1) begin : g_latency_check
    $error("dmem_responder: LATENCY must be at least 1");
  end

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic              we_q, we_d;
  mem_size_t         size_q, size_d;
  logic              uns_q, uns_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;

  logic [31:0]       rsp_rdata_q, rsp_rdata_d;
  logic              rsp_err_q, rsp_err_d;

  logic [31:0]       mem_q [DEPTH_WORDS];

  // Request as seen at the commit edge (live inputs when committing on the accept edge).
  logic              c_we;
  mem_size_t         c_size;
  logic              c_uns;
  logic [ADDR_W-1:0] c_addr;
  logic [31:0]       c_wdata;
  logic              c_err;
  logic [IDX_W-1:0]  c_idx;
  logic              commit;

  logic [3:0]        st_be;
  logic [31:0]       st_word;
  logic [31:0]       rd_word;
  logic [31:0]       ld_data;

  // Select the request being committed and classify it.
  always_comb begin
    c_we    = we_q;
    c_size  = size_q;
    c_uns   = uns_q;
    c_addr  = addr_q;
    c_wdata = wdata_q;
    if (LATENCY == 1 && state_q == IDLE) begin
      c_we    = bus.req_we;
      c_size  = bus.req_size;
      c_uns   = bus.req_unsigned;
      c_addr  = bus.req_addr;
      c_wdata = bus.req_wdata;
    end
    c_err   = (c_size == MEM_SIZE_RSV)
            || mem_misaligned(c_size, c_addr[1:0])
            || ({2'b00, c_addr[ADDR_W-1:2]} >= DEPTH_L);
    c_idx   = c_addr[IDX_W+1:2];
    rd_word = mem_q[c_idx];
  end

  dmem_lane_align u_lane_align (
    .size        (c_size),
    .addr_lo     (c_addr[1:0]),
    .is_unsigned (c_uns),
    .st_data     (c_wdata),
    .st_be       (st_be),
    .st_word     (st_word),
    .ld_word     (rd_word),
    .ld_data     (ld_data)
  );

  // Next-state, request capture and commit strobe.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    size_d  = size_q;
    uns_d   = uns_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    commit  = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          we_d    = bus.req_we;
          size_d  = bus.req_size;
          uns_d   = bus.req_unsigned;
          addr_d  = bus.req_addr;
          wdata_d = bus.req_wdata;
          if (LATENCY == 1) begin
            state_d = RESP;
            commit  = 1'b1;
          end else begin
            state_d = WAIT;
            cnt_d   = CNT_INIT;
          end
        end
      end
      WAIT: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = RESP;
          commit  = 1'b1;
        end
      end
      RESP: begin
        if (bus.rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Response payload: captured at the commit edge, held until the handshake.
  always_comb begin
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    if (commit) begin
      rsp_err_d   = c_err;
      rsp_rdata_d = (c_err || c_we) ? 32'h0 : ld_data;
    end
  end

  // Control and response registers; reset wins over everything.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  // Captured request fields; meaningful only while a request is in flight.
  always_ff @(posedge clk) begin
    we_q    <= we_d;
    size_q  <= size_d;
    uns_q   <= uns_d;
    addr_q  <= addr_d;
    wdata_q <= wdata_d;
  end

  // Array write of the enabled lanes at commit; a reset on that edge drops the store.
  always_ff @(posedge clk) begin
    if (!reset && commit && c_we && !c_err) begin
      for (int i = 0; i < 4; i++) begin
        if (st_be[i]) mem_q[c_idx][8*i +: 8] <= st_word[8*i +: 8];
      end
    end
  end

  assign bus.req_ready = (state_q == IDLE);
  assign bus.rsp_valid = (state_q == RESP);
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: a LATENCY=2 and a LATENCY=1 instance side by side,
// checked every cycle against a byte-array transaction model.
module tb_dmem_responder;
  import dmem_responder_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // Stimulus per instance (index 0: LATENCY=2, index 1: LATENCY=1)
  logic        rq_valid [2];
  logic        rq_we    [2];
  logic        rq_uns   [2];
  logic        rs_ready [2];
  logic [1:0]  rq_size  [2];
  logic [31:0] rq_addr  [2];
  logic [31:0] rq_wdata [2];

  wire         o_rdy [2];
  wire         o_vld [2];
  wire         o_err [2];
  wire  [31:0] o_rd  [2];

  dmem_responder_if #(.ADDR_W(32)) bus0 ();
  dmem_responder_if #(.ADDR_W(32)) bus1 ();

  assign bus0.req_valid    = rq_valid[0];
  assign bus0.req_we       = rq_we[0];
  assign bus0.req_size     = mem_size_t'(rq_size[0]);
  assign bus0.req_unsigned = rq_uns[0];
  assign bus0.req_addr     = rq_addr[0];
  assign bus0.req_wdata    = rq_wdata[0];
  assign bus0.rsp_ready    = rs_ready[0];
  assign o_rdy[0]          = bus0.req_ready;
  assign o_vld[0]          = bus0.rsp_valid;
  assign o_err[0]          = bus0.rsp_err;
  assign o_rd[0]           = bus0.rsp_rdata;

  assign bus1.req_valid    = rq_valid[1];
  assign bus1.req_we       = rq_we[1];
  assign bus1.req_size     = mem_size_t'(rq_size[1]);
  assign bus1.req_unsigned = rq_uns[1];
  assign bus1.req_addr     = rq_addr[1];
  assign bus1.req_wdata    = rq_wdata[1];
  assign bus1.rsp_ready    = rs_ready[1];
  assign o_rdy[1]          = bus1.req_ready;
  assign o_vld[1]          = bus1.rsp_valid;
  assign o_err[1]          = bus1.rsp_err;
  assign o_rd[1]           = bus1.rsp_rdata;

  dmem_responder #(.ADDR_W(32), .DEPTH_WORDS(1024), .LATENCY(2)) dut (
    .clk(clk), .reset(rst), .bus(bus0)
  );

  dmem_responder #(.ADDR_W(32), .DEPTH_WORDS(1024), .LATENCY(1)) dut_l1 (
    .clk(clk), .reset(rst), .bus(bus1)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, got, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  longint      k = 0;
  logic        m_busy [2];
  logic        m_vld  [2];
  logic        m_er   [2];
  logic [31:0] m_rd   [2];
  longint      m_at   [2];
  int          m_acc  [2] = '{0, 0};
  logic        m_we   [2];
  logic        m_uns  [2];
  logic [1:0]  m_sz   [2];
  logic [31:0] m_a    [2];
  logic [31:0] m_wd   [2];
  logic [7:0]  bm     [2][4096];

  function automatic int lat_of(input int d);
    return (d == 0) ? 2 : 1;
  endfunction

  function automatic logic ref_err(input logic [1:0] sz, input logic [31:0] a);
    return (sz == 2'd3) || (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'b00)
        || ((a >> 2) >= 32'd1024);
  endfunction

  always @(posedge clk) begin : model
    int nb;
    logic [31:0] v;
    k++;
    for (int d = 0; d < 2; d++) begin
      if (rst) begin
        m_busy[d] = 1'b0;
        m_vld[d]  = 1'b0;
        m_rd[d]   = 32'h0;
        m_er[d]   = 1'b0;
      end else begin
        if (!m_busy[d]) begin
          if (rq_valid[d]) begin
            m_busy[d] = 1'b1;
            m_at[d]   = k + lat_of(d) - 1;
            m_we[d]   = rq_we[d];
            m_uns[d]  = rq_uns[d];
            m_sz[d]   = rq_size[d];
            m_a[d]    = rq_addr[d];
            m_wd[d]   = rq_wdata[d];
            m_acc[d]++;
          end
        end else if (m_vld[d] && rs_ready[d]) begin
          m_busy[d] = 1'b0;
          m_vld[d]  = 1'b0;
        end
        if (m_busy[d] && !m_vld[d] && k == m_at[d]) begin
          m_vld[d] = 1'b1;
          m_er[d]  = ref_err(m_sz[d], m_a[d]);
          m_rd[d]  = 32'h0;
          if (!m_er[d]) begin
            nb = 1 << m_sz[d];
            if (m_we[d]) begin
              for (int i = 0; i < nb; i++) bm[d][m_a[d][11:0] + 12'(i)] = m_wd[d][8*i +: 8];
            end else begin
              v = 32'h0;
              for (int i = 0; i < nb; i++) v = v | (32'(bm[d][m_a[d][11:0] + 12'(i)]) << (8*i));
              if (!m_uns[d] && nb < 4 && v[8*nb-1]) v = v | (32'hFFFF_FFFF << (8*nb));
              m_rd[d] = v;
            end
          end
        end
      end
    end
  end

  // Every-cycle comparison of DUT outputs against the model.
  always @(negedge clk) begin
    if (k > 0) begin
      for (int d = 0; d < 2; d++) begin
        chk($sformatf("req_ready[%0d]", d), 32'(o_rdy[d]), 32'(!m_busy[d]));
        chk($sformatf("rsp_valid[%0d]", d), 32'(o_vld[d]), 32'(m_vld[d]));
        if (m_vld[d]) begin
          chk($sformatf("rsp_rdata[%0d]", d), o_rd[d], m_rd[d]);
          chk($sformatf("rsp_err[%0d]", d), 32'(o_err[d]), 32'(m_er[d]));
        end
      end
    end
  end

  // ---------------- driver ----------------
  task automatic do_req(input int d, input logic we, input logic [1:0] sz, input logic uns,
                        input logic [31:0] a, input logic [31:0] wd, input int hold,
                        input logic spurious, output logic [31:0] rd, output logic er);
    int n;
    logic rdy;
    rd = 32'h0;
    er = 1'b0;
    rq_valid[d] = 1'b1;
    rq_we[d]    = we;
    rq_size[d]  = sz;
    rq_uns[d]   = uns;
    rq_addr[d]  = a;
    rq_wdata[d] = wd;
    rs_ready[d] = (hold == 0);
    n = 0;
    do begin
      rdy = o_rdy[d];
      @(negedge clk);
      n++;
    end while (!rdy && n < 50);
    rq_valid[d] = 1'b0;
    if (!rdy) begin
      chk("accept_timeout", 32'(rdy), 32'd1);
      return;
    end
    n = 0;
    while (!o_vld[d] && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!o_vld[d]) begin
      chk("response_timeout", 32'(o_vld[d]), 32'd1);
      rs_ready[d] = 1'b0;
      return;
    end
    rd = o_rd[d];
    er = o_err[d];
    if (hold > 0) begin
      if (spurious) begin
        rq_valid[d] = 1'b1;
        rq_we[d]    = 1'b1;
        rq_size[d]  = 2'd2;
        rq_addr[d]  = 32'h20;
        rq_wdata[d] = $urandom;
      end
      repeat (hold) @(negedge clk);
      rq_valid[d] = 1'b0;
      rs_ready[d] = 1'b1;
    end
    @(negedge clk);
    rs_ready[d] = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [31:0] rd;
    logic        er;
    int          a0;
    int          dd;
    logic [1:0]  rsz;
    logic [31:0] ra;
    int          r;
    for (int d = 0; d < 2; d++) begin
      rq_valid[d] = 1'b0; rq_we[d] = 1'b0; rq_uns[d] = 1'b0; rs_ready[d] = 1'b0;
      rq_size[d] = 2'd0; rq_addr[d] = 32'h0; rq_wdata[d] = 32'h0;
    end
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk("reset_rsp_valid", 32'(o_vld[d]), 32'd0);
      chk("reset_req_ready", 32'(o_rdy[d]), 32'd1);
      chk("reset_rsp_rdata", o_rd[d], 32'h0);
      chk("reset_rsp_err", 32'(o_err[d]), 32'd0);
    end

    // Fill the working region 0x00-0x3F of both arrays.
    for (int w = 0; w < 16; w++) begin
      for (int d = 0; d < 2; d++) begin
        do_req(d, 1'b1, 2'd2, 1'b0, 32'(w * 4), (w == 8) ? 32'hCAFE_F00D : $urandom, 0, 1'b0, rd, er);
      end
    end

    // Directed word/byte/half accesses
    do_req(0, 1'b1, 2'd2, 1'b0, 32'h10, 32'hDEAD_BEEF, 0, 1'b0, rd, er);
    do_req(0, 1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 0, 1'b0, rd, er);
    chk("lw_deadbeef", rd, 32'hDEAD_BEEF);
    chk("lw_deadbeef_err", 32'(er), 32'd0);
    do_req(0, 1'b1, 2'd0, 1'b0, 32'h13, 32'h80, 0, 1'b0, rd, er);
    do_req(0, 1'b0, 2'd0, 1'b0, 32'h13, 32'h0, 0, 1'b0, rd, er);
    chk("lb_sext", rd, 32'hFFFF_FF80);
    do_req(0, 1'b0, 2'd0, 1'b1, 32'h13, 32'h0, 0, 1'b0, rd, er);
    chk("lbu_zext", rd, 32'h0000_0080);
    do_req(0, 1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 0, 1'b0, rd, er);
    chk("lw_after_sb", rd, 32'h80AD_BEEF);
    do_req(0, 1'b1, 2'd1, 1'b0, 32'h10, 32'h1234, 0, 1'b0, rd, er);
    do_req(0, 1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 0, 1'b0, rd, er);
    chk("lw_after_sh", rd, 32'h80AD_1234);

    // Error cases
    do_req(0, 1'b0, 2'd1, 1'b0, 32'h11, 32'h0, 0, 1'b0, rd, er);
    chk("lh_misaligned_err", 32'(er), 32'd1);
    chk("lh_misaligned_rdata", rd, 32'h0);
    do_req(0, 1'b1, 2'd2, 1'b0, 32'h12, 32'hFFFF_FFFF, 0, 1'b0, rd, er);
    chk("sw_misaligned_err", 32'(er), 32'd1);
    do_req(0, 1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 0, 1'b0, rd, er);
    chk("lw_unchanged", rd, 32'h80AD_1234);
    do_req(0, 1'b0, 2'd3, 1'b0, 32'h10, 32'h0, 0, 1'b0, rd, er);
    chk("size3_err", 32'(er), 32'd1);
    do_req(0, 1'b0, 2'd2, 1'b0, 32'h1000, 32'h0, 0, 1'b0, rd, er);
    chk("out_of_range_err", 32'(er), 32'd1);

    // Response back-pressure with a stray request during RESP
    do_req(0, 1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 5, 1'b1, rd, er);
    chk("held_rdata", rd, 32'h80AD_1234);

    // Reset while a store waits for its commit edge
    rq_valid[0] = 1'b1; rq_we[0] = 1'b1; rq_size[0] = 2'd2; rq_uns[0] = 1'b0;
    rq_addr[0] = 32'h20; rq_wdata[0] = 32'h1234_5678; rs_ready[0] = 1'b1;
    @(negedge clk);
    rq_valid[0] = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    rs_ready[0] = 1'b0;
    chk("reset_wait_rsp_valid", 32'(o_vld[0]), 32'd0);
    chk("reset_wait_req_ready", 32'(o_rdy[0]), 32'd1);
    do_req(0, 1'b0, 2'd2, 1'b0, 32'h20, 32'h0, 0, 1'b0, rd, er);
    chk("store_dropped", rd, 32'hCAFE_F00D);

    // Back-to-back loads with rsp_ready held high
    for (int d = 0; d < 2; d++) begin
      a0 = m_acc[d];
      rq_we[d] = 1'b0; rq_size[d] = 2'd2; rq_uns[d] = 1'b0; rq_addr[d] = 32'h10;
      rs_ready[d] = 1'b1;
      rq_valid[d] = 1'b1;
      repeat (20) @(negedge clk);
      rq_valid[d] = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rs_ready[d] = 1'b0;
      chk($sformatf("b2b_accepts[%0d]", d), 32'(m_acc[d] - a0), (d == 0) ? 32'd7 : 32'd10);
    end

    // Randomised traffic on both instances
    for (int t = 0; t < 240; t++) begin
      dd  = t % 2;
      rsz = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      r   = $urandom_range(0, 19);
      if (r == 0)      ra = 32'h0000_1000 | $urandom;
      else if (r == 1) ra = 32'h1000 + 32'($urandom_range(0, 15));
      else             ra = 32'($urandom_range(0, 63));
      do_req(dd, 1'($urandom_range(0, 1)), rsz, 1'($urandom_range(0, 1)), ra, $urandom,
             $urandom_range(0, 3), 1'($urandom_range(0, 1)), rd, er);
    end

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
